mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single `genrom` read port between the core's instruction-fetch unit and its data/operand unit. Round-robin arbitration with a pipelined, owner-tagged return path: one grant per cycle, responses routed back in order. Sits between `core` and `genrom`; its ROM side connects to `mem_addr`/`mem_extra`/`mem_data`/`mem_error` unchanged. A fetch-flush input squashes in-flight fetch responses on control-flow changes (`if`/`br`/`end`).

## Interface
- `MEM_DEPTH`, 5: ROM address MSB index; address width is MEM_DEPTH+1.
- `MEM_EXTRA`, 4: extra-byte field width; data width DW = 2**MEM_EXTRA*8.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held until `f_gnt`.
- `f_addr`  in  MEM_DEPTH+1  fetch byte address.
- `f_extra`  in  MEM_EXTRA  fetch extra-byte count.
- `f_gnt`  out  1  combinational grant; request accepted at this edge.
- `f_flush`  in  1  discard all fetch responses in flight (not yet returned).
- `f_valid`  out  1  fetch response valid (one cycle).
- `f_data`  out  DW  fetch read data.
- `f_error`  out  1  ROM error for this response.
- `d_req`, `d_addr`, `d_extra`, `d_gnt`, `d_valid`, `d_data`, `d_error`: same as fetch, data requester; no flush.
- `mem_addr`  out  MEM_DEPTH+1  registered ROM address.
- `mem_extra`  out  MEM_EXTRA  registered ROM extra count.
- `mem_data`  in  DW  ROM data, valid one cycle after `mem_addr`.
- `mem_error`  in  1  ROM error, same timing as `mem_data`.

## Operation
- Arbitration, combinational every cycle: only one requester -> grant it; both -> grant the one not in `last` register; none -> no grant. `f_gnt`/`d_gnt` never both high.
- `last` updated to winner on each granted edge; reset value = fetch (so first contention grants data).
- On granted edge: `mem_addr`/`mem_extra` <- winner's addr/extra; owner tag stage 1 <- {valid=1, owner}.
- Ungranted cycle: `mem_addr`/`mem_extra` hold; stage 1 valid <- 0.
- Tag pipeline: stage 1 -> stage 2 each edge. Stage 2 valid with owner fetch -> `f_valid`=1; owner data -> `d_valid`=1.
- `f_data`/`d_data` = `mem_data` and `f_error`/`d_error` = `mem_error` combinationally, gated by the corresponding valid (0 when not valid).
- `f_flush` high at an edge: clears valid of every fetch-owned tag in stages 1 and 2 before they advance; data tags unaffected. A fetch granted in the same cycle as `f_flush` is NOT squashed (new target address).
- `f_flush` also forces `f_valid` low combinationally in that cycle.
- Addresses pass unmodified; no bound checking (ROM reports `mem_error`).

## Timing
- Grant cycle N -> `mem_addr` valid cycle N+1 -> `x_valid`/data cycle N+2. Latency 2 edges, fixed.
- Throughput 1 access/cycle; back-to-back grants allowed; responses in grant order.
- Continuous contention: strict alternation F,D,F,D... starting with D after reset.
- Reset (async, `reset`=0): `mem_addr`=0, `mem_extra`=0, tags invalid, `last`=fetch; all `*_valid`, `*_data`, `*_error` = 0; grants still combinational but ignored while in reset. Reset mid-flight drops all pending responses.
- Requester must keep req/addr/extra stable until granted; changing them before grant is allowed and the value at the grant edge is used.

## Test plan
- Single fetch: `f_req`=1, addr 0x04, extra 3 one cycle -> `f_gnt`=1 that cycle, `mem_addr`=0x04 next cycle, `f_valid`=1 two cycles after with `f_data`=ROM bytes 4..7; `d_valid` stays 0.
- Contention from reset: both req held 4 cycles, addrs 0x00/0x10 -> grants D,F,D,F; `d_valid`,`f_valid` alternate from cycle 2 with correct data.
- Back-to-back fetch 0x00,0x01,0x02 on consecutive cycles -> three consecutive `f_valid` pulses, data in order.
- Flush: fetches at 0x00,0x01 then `f_flush` with new fetch 0x08 same cycle -> no responses for 0x00/0x01, one `f_valid` for 0x08; interleaved data response still delivered.
- Error: request to out-of-bound address with ROM bounds narrowed -> `d_error`=1 with `d_valid`; next valid access `d_error`=0.
- Async reset asserted between grant and response -> all outputs 0 immediately; no stale `f_valid` after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and ROM-side signal around mem_port_arbiter.
// The arbiter uses the slave modport; the surrounding core/ROM (or a bench)
// uses the master modport. dbg_state exposes the arbiter's internal state:
//   [4] last winner (0 = fetch, 1 = data)
//   [3] stage 1 tag valid   [2] stage 1 tag owner
//   [1] stage 2 tag valid   [0] stage 2 tag owner
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int MEM_DEPTH = 5,
  parameter int MEM_EXTRA = 4
);
  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  // fetch requester
  logic                 f_req;
  logic [AW-1:0]        f_addr;
  logic [MEM_EXTRA-1:0] f_extra;
  logic                 f_gnt;
  logic                 f_flush;
  logic                 f_valid;
  logic [DW-1:0]        f_data;
  logic                 f_error;

  // data/operand requester
  logic                 d_req;
  logic [AW-1:0]        d_addr;
  logic [MEM_EXTRA-1:0] d_extra;
  logic                 d_gnt;
  logic                 d_valid;
  logic [DW-1:0]        d_data;
  logic                 d_error;

  // ROM read port
  logic [AW-1:0]        mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0]        mem_data;
  logic                 mem_error;

  // internal state for checkers and debug
  logic [4:0]           dbg_state;

  modport slave (
    input  f_req, f_addr, f_extra, f_flush,
    output f_gnt, f_valid, f_data, f_error,
    input  d_req, d_addr, d_extra,
    output d_gnt, d_valid, d_data, d_error,
    output mem_addr, mem_extra,
    input  mem_data, mem_error,
    output dbg_state
  );

  modport master (
    output f_req, f_addr, f_extra, f_flush,
    input  f_gnt, f_valid, f_data, f_error,
    output d_req, d_addr, d_extra,
    input  d_gnt, d_valid, d_data, d_error,
    input  mem_addr, mem_extra,
    output mem_data, mem_error,
    input  dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single genrom read port between the
// instruction-fetch and data/operand units. One grant per cycle, registered
// ROM address, and a two-stage owner tag pipeline that routes each ROM
// response back to the unit that asked for it, in grant order.
//
// Handshake: a requester raises x_req with stable x_addr/x_extra and keeps
// them until x_gnt is seen high in the same cycle; the request is accepted
// at that rising edge. Exactly two edges later x_valid pulses for one cycle
// with x_data/x_error. There is no back-pressure on the response side.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int MEM_DEPTH = 5,
  parameter int MEM_EXTRA = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Round-robin pointer: the requester that won most recently.
  owner_e               last_q;

  // ROM address/extra registers driving genrom directly.
  logic [AW-1:0]        mem_addr_q;
  logic [MEM_EXTRA-1:0] mem_extra_q;

  // Stage 1 describes the access whose address is on mem_addr now;
  // stage 2 describes the access whose data is on mem_data now.
  logic                 s1_valid_q;
  owner_e               s1_owner_q;
  logic                 s2_valid_q;
  owner_e               s2_owner_q;

  // Combinational arbitration results.
  logic                 gnt_f;
  logic                 gnt_d;
  logic                 gnt_any;
  owner_e               winner;
  logic [AW-1:0]        win_addr;
  logic [MEM_EXTRA-1:0] win_extra;

  // Response routing.
  logic                 f_hit;
  logic                 d_hit;
  logic                 s1_keep;

  // Grant a lone requester outright; under contention grant the one that
  // did not win last time, so continuous contention alternates.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (bus.f_req && bus.d_req) begin
      if (last_q == OWN_FETCH) begin
        gnt_d = 1'b1;
      end else begin
        gnt_f = 1'b1;
      end
    end else if (bus.f_req) begin
      gnt_f = 1'b1;
    end else if (bus.d_req) begin
      gnt_d = 1'b1;
    end
  end

  // Select the winning requester's address and extra count.
  always_comb begin
    gnt_any   = gnt_f | gnt_d;
    winner    = OWN_FETCH;
    win_addr  = bus.f_addr;
    win_extra = bus.f_extra;
    if (gnt_d) begin
      winner    = OWN_DATA;
      win_addr  = bus.d_addr;
      win_extra = bus.d_extra;
    end
  end

  assign bus.f_gnt = gnt_f;
  assign bus.d_gnt = gnt_d;

  // Launch the granted access on the ROM port and remember the winner.
  // Without a grant the address holds so the ROM inputs stay quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
      last_q      <= OWN_FETCH;
    end else if (gnt_any) begin
      mem_addr_q  <= win_addr;
      mem_extra_q <= win_extra;
      last_q      <= winner;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_extra = mem_extra_q;

  // A flush kills fetch tags already launched; the fetch granted in the
  // flush cycle carries the new target, so it enters stage 1 untouched.
  always_comb begin
    s1_keep = s1_valid_q && !(bus.f_flush && (s1_owner_q == OWN_FETCH));
  end

  // Advance the owner tag pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_owner_q <= OWN_FETCH;
      s2_valid_q <= 1'b0;
      s2_owner_q <= OWN_FETCH;
    end else begin
      s1_valid_q <= gnt_any;
      s1_owner_q <= winner;
      s2_valid_q <= s1_keep;
      s2_owner_q <= s1_owner_q;
    end
  end

  // Route the ROM response to its owner; a flush suppresses a fetch
  // response arriving in the same cycle.
  always_comb begin
    f_hit = s2_valid_q && (s2_owner_q == OWN_FETCH) && !bus.f_flush;
    d_hit = s2_valid_q && (s2_owner_q == OWN_DATA);
  end

  // Gate data and error with valid so idle outputs read as zero.
  always_comb begin
    bus.f_valid = f_hit;
    bus.f_data  = f_hit ? bus.mem_data : '0;
    bus.f_error = f_hit & bus.mem_error;
    bus.d_valid = d_hit;
    bus.d_data  = d_hit ? bus.mem_data : '0;
    bus.d_error = d_hit & bus.mem_error;
  end

  assign bus.dbg_state = {last_q, s1_valid_q, s1_owner_q, s2_valid_q, s2_owner_q};

  // Keep the data width tied to the bus so a parameter mismatch is obvious.
  logic [DW-1:0] unused_width_probe;
  assign unused_width_probe = bus.mem_data;

endmodule
